// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int RESET_PC_DEF   = 0;
   localparam int IMEM_DEPTH_DEF = 64;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline slot: holds one fetched instruction and its word address.
// Priority is flush, then load, then drain.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_drain,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc
);

   logic            r_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures the combinational IMEM word
// into the IF/ID slot. Optional perf counters under FETCH_PERF_EN.
//
// state   | meaning
// S_BOOT  | one idle cycle after reset while the IMEM clears
// S_RUN   | normal sequential fetch
// S_FAULT | PC left the IMEM range; waits for a redirect
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int RESET_PC   = RESET_PC_DEF,
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic [XLEN-1:0] i_imem_rdata,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_id_valid,
   input  logic            i_id_ready,
   output logic [XLEN-1:0] o_id_instr,
   output logic [XLEN-1:0] o_id_pc,
   output logic            o_fetch_fault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     o_perf_fetch_cnt,
   output logic [31:0]     o_perf_stall_cnt
`endif
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_fault;

   logic w_valid;
   logic w_slot_free;
   logic w_in_range;
   logic w_run;
   logic w_accept;
   logic w_fault_hit;

   assign w_slot_free = !w_valid || i_id_ready;
   assign w_in_range  = (r_pc < XLEN'(IMEM_DEPTH));
   assign w_run       = (r_state == S_RUN);
   assign w_accept    = w_run && w_slot_free && w_in_range;
   assign w_fault_hit = w_run && w_slot_free && !w_in_range;

   // Redirect outranks every state transition, including the boot cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_BOOT;
         r_pc    <= XLEN'(RESET_PC);
         r_fault <= 1'b0;
      end else if (i_redirect_valid) begin
         r_state <= S_RUN;
         r_pc    <= i_redirect_pc;
         r_fault <= 1'b0;
      end else begin
         case (r_state)
            S_BOOT: r_state <= S_RUN;
            S_RUN: begin
               if (w_accept) begin
                  r_pc <= r_pc + XLEN'(1);
               end else if (w_fault_hit) begin
                  r_fault <= 1'b1;
                  r_state <= S_FAULT;
               end
            end
            S_FAULT: r_state <= S_FAULT;
            default: r_state <= S_BOOT;
         endcase
      end
   end

   if_id_reg #(
      .XLEN (XLEN)
   ) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_accept && !i_redirect_valid),
      .i_drain (w_valid && i_id_ready),
      .i_flush (i_redirect_valid),
      .i_instr (i_imem_rdata),
      .i_pc    (r_pc),
      .o_valid (w_valid),
      .o_instr (o_id_instr),
      .o_pc    (o_id_pc)
   );

   assign o_imem_addr   = r_pc;
   assign o_id_valid    = w_valid;
   assign o_fetch_fault = r_fault;

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_fetch_cnt <= '0;
         r_perf_stall_cnt <= '0;
      end else begin
         if (w_accept)
            r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         if (w_valid && !i_id_ready)
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
   end

   assign o_perf_fetch_cnt = r_perf_fetch_cnt;
   assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random handshake/redirect traffic against
// an expected-stream scoreboard, then directed timing scenarios.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redir;
   logic [31:0] redir_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        fault;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;
`endif

   int n_chk = 0;
   int n_pass = 0;
   int n_consumed = 0;
   bit mon_en = 1'b0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   // Instruction memory: word k holds 0x1000+k.
   assign imem_rdata = 32'h1000 + imem_addr;

   fetch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .o_imem_addr      (imem_addr),
      .i_imem_rdata     (imem_rdata),
      .i_redirect_valid (redir),
      .i_redirect_pc    (redir_pc),
      .o_id_valid       (id_valid),
      .i_id_ready       (id_ready),
      .o_id_instr       (id_instr),
      .o_id_pc          (id_pc),
      .o_fetch_fault    (fault)
`ifdef FETCH_PERF_EN
      ,
      .o_perf_fetch_cnt (perf_fetch),
      .o_perf_stall_cnt (perf_stall)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Whatever decode consumes from now on must be start, start+1, ... up to
   // the last in-range word; nothing past the end of memory.
   task automatic load_stream(input int unsigned start);
      exp_q.delete();
      for (int unsigned a = start; a < 64; a++) exp_q.push_back(a);
   endtask

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && id_valid && id_ready && !redir) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_delivery: got pc 0x%08h expected none", id_pc);
            end else begin
               e = exp_q.pop_front();
               chk("stream_pc", id_pc, e);
               chk("stream_instr", id_instr, 32'h1000 + e);
               n_consumed++;
            end
         end
      end
   end

   initial begin
      int unsigned tgt;
      rst_n = 1'b0; id_ready = 1'b0; redir = 1'b0; redir_pc = '0;

      // Random phase
      cyc(); cyc();
      rst_n = 1'b1;
      load_stream(0);
      mon_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         cyc();
         id_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 24) == 0) begin
            tgt      = $urandom_range(0, 70);
            redir    = 1'b1;
            redir_pc = tgt;
            load_stream(tgt);
         end else begin
            redir = 1'b0;
         end
      end
      redir = 1'b0;
      cyc();
      mon_en = 1'b0;
      chk("stream_progress", (n_consumed > 200) ? 32'd1 : 32'd0, 32'd1);

      // Reset then run
      rst_n = 1'b0; id_ready = 1'b1;
      cyc(); cyc(); cyc();
      rst_n = 1'b1;
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_instr", id_instr, 32'd0);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      cyc();
      chk("boot_valid", 32'(id_valid), 32'd0);
      cyc();
      chk("first_valid", 32'(id_valid), 32'd1);
      chk("first_pc", id_pc, 32'd0);
      chk("first_instr", id_instr, 32'h1000);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         chk("seq_valid", 32'(id_valid), 32'd1);
         chk("seq_pc", id_pc, k);
         chk("seq_instr", id_instr, 32'h1000 + k);
      end

      // Stall four cycles at id_pc=5
      id_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (s != 0) cyc();
         chk("stall_pc", id_pc, 32'd5);
         chk("stall_instr", id_instr, 32'h1005);
         chk("stall_addr", imem_addr, 32'd6);
         chk("stall_valid", 32'(id_valid), 32'd1);
      end
      cyc();
      id_ready = 1'b1;
      cyc();
      chk("resume_pc", id_pc, 32'd6);
`ifdef FETCH_PERF_EN
      chk("perf_stall", perf_stall, 32'd4);
`endif

      // Redirect while slot full and stalled
      id_ready = 1'b0; redir = 1'b1; redir_pc = 32'd40;
      cyc();
      redir = 1'b0;
      chk("redir_flush", 32'(id_valid), 32'd0);
      id_ready = 1'b1;
      cyc();
      chk("redir_valid", 32'(id_valid), 32'd1);
      chk("redir_pc", id_pc, 32'd40);
      chk("redir_instr", id_instr, 32'h1028);

      // Run off the end of memory
      redir = 1'b1; redir_pc = 32'd62;
      cyc();
      redir = 1'b0;
      chk("flt_bubble", 32'(id_valid), 32'd0);
      cyc();
      chk("flt_pc62", id_pc, 32'd62);
      cyc();
      chk("flt_pc63", id_pc, 32'd63);
      chk("flt_addr", imem_addr, 32'd64);
      chk("flt_pre", 32'(fault), 32'd0);
      for (int s = 0; s < 4; s++) begin
         cyc();
         chk("flt_set", 32'(fault), 32'd1);
         chk("flt_novalid", 32'(id_valid), 32'd0);
         chk("flt_addr_hold", imem_addr, 32'd64);
      end
      redir = 1'b1; redir_pc = 32'd0;
      cyc();
      redir = 1'b0;
      chk("flt_clear", 32'(fault), 32'd0);
      chk("flt_clear_valid", 32'(id_valid), 32'd0);
      cyc();
      chk("flt_recover_valid", 32'(id_valid), 32'd1);
      chk("flt_recover_pc", id_pc, 32'd0);

      // Redirect coinciding with an accept at pc=10
      for (int k = 0; k < 9; k++) cyc();
      chk("pre_sim_addr", imem_addr, 32'd10);
      redir = 1'b1; redir_pc = 32'd20;
      cyc();
      redir = 1'b0;
      chk("sim_flush", 32'(id_valid), 32'd0);
      cyc();
      chk("sim_valid", 32'(id_valid), 32'd1);
      chk("sim_pc", id_pc, 32'd20);

      // Reset mid-stream, then redirect during the boot cycle
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("mid_rst_valid", 32'(id_valid), 32'd0);
      chk("mid_rst_fault", 32'(fault), 32'd0);
      chk("mid_rst_addr", imem_addr, 32'd0);
      redir = 1'b1; redir_pc = 32'd30;
      cyc();
      redir = 1'b0;
      chk("boot_redir_bubble", 32'(id_valid), 32'd0);
      cyc();
      chk("boot_redir_valid", 32'(id_valid), 32'd1);
      chk("boot_redir_pc", id_pc, 32'd30);
      chk("boot_redir_instr", id_instr, 32'h101E);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-issue core. It owns the program counter and drives the word address into the instruction memory, whose read is combinational. It registers the returned word plus its PC into the IF/ID slot and hands that slot to decode with a valid/ready handshake. It also handles decode stalls, branch/jump redirects (flush), and out-of-range fetch faults.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 0, word address fetched first after reset
- IMEM_DEPTH, 64, number of instruction words; word addresses >= IMEM_DEPTH are out of range
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- imem_addr  out  XLEN  word address to instruction memory; equals current PC register
- imem_rdata  in  XLEN  instruction word at imem_addr, valid in the same cycle
- redirect_valid  in  1  taken branch/jump from execute; one-cycle pulse
- redirect_pc  in  XLEN  target word address, sampled when redirect_valid=1
- id_valid  out  1  IF/ID slot holds an instruction
- id_ready  in  1  decode accepts the slot this cycle
- id_instr  out  XLEN  registered instruction
- id_pc  out  XLEN  word address of id_instr
- fetch_fault  out  1  sticky; fetch attempted at PC >= IMEM_DEPTH

## Operation
- **Reset** (rst_n=0 at posedge):
  - pc=RESET_PC, state=S_BOOT
  - id_valid=0, id_instr=0, id_pc=0, fetch_fault=0
  - Reset mid-operation discards the slot contents immediately.
- **FSM:**
  - S_BOOT: no capture. Next state S_RUN unconditionally; covers the instruction memory's own reset clear.
  - S_RUN: normal fetch.
  - S_FAULT: no capture, pc held. Exit only on redirect (-> S_RUN) or reset.
- **PC** counts words: sequential next = pc+1, modulo 2^XLEN (wrap, no flag).
- **accept** = (state==S_RUN) && (!id_valid || id_ready) && (pc < IMEM_DEPTH).
- **On accept:** id_instr<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+1.
- **Decode takes the slot but no accept** (id_valid && id_ready && !accept): id_valid<=0.
- **Stall** (id_valid && !id_ready): pc, id_instr, id_pc, id_valid all held; imem_addr stable.
- **Fault:** in S_RUN with slot free and pc >= IMEM_DEPTH:
  - No capture; fetch_fault<=1, state<=S_FAULT.
  - A valid slot still drains normally via id_ready.
- **Redirect has highest priority**, in any state except reset:
  - pc<=redirect_pc, id_valid<=0 (flush, regardless of id_ready), fetch_fault<=0, state<=S_RUN.
  - Redirect in the same cycle as accept or fault: redirect wins; that fetch is discarded.
- Redirect in S_BOOT is honoured; state goes to S_RUN.

## Timing
- imem_addr = pc register output, no combinational path from inputs.
- **Fetch latency:** 1 cycle. Address in cycle N gives id_valid/id_instr in cycle N+1.
- **Throughput:** 1 instruction/cycle while id_ready=1.
- **After reset release:** S_BOOT cycle, then first accept, so id_valid=1 in the 2nd cycle after the first cycle with rst_n=1.
- **Redirect asserted in cycle N:**
  - id_valid=0 in N+1.
  - Target instruction valid in N+2 (one bubble).
- **Outputs:** id_valid, id_instr, id_pc, fetch_fault are registered. No input-to-output combinational path except none (id_ready feeds only next-state logic).

## Configuration
- **FETCH_PERF_EN** defined adds:
  - perf_fetch_cnt (out, 32): counts accepts.
  - perf_stall_cnt (out, 32): counts cycles with id_valid && !id_ready.
  - Both reset to 0, wrap at 2^32, and are unaffected by redirect.
- **Not defined:** the ports and counters are absent; behaviour is otherwise identical.

## Structure
- **Package fetch_pkg:**
  - fetch_state_t enum {S_BOOT, S_RUN, S_FAULT}
  - default XLEN, RESET_PC, IMEM_DEPTH constants
- **Sub-module if_id_reg:** valid/instr/pc slot with load, drain and flush inputs, instantiated once.
- PC, FSM, fault logic and perf counters stay in fetch_unit.

## Test plan
- **Reset then run:** rst_n low 3 cycles then high, id_ready=1, memory word k = 0x1000+k.
  - id_valid rises in the 2nd cycle after release.
  - id_pc = 0,1,2,… and id_instr = 0x1000,0x1001,… on consecutive cycles.
- **Stall:** id_ready=0 for 4 cycles while id_pc=5.
  - id_pc=5, id_instr=0x1005 and imem_addr=6 held for all 4 cycles.
  - Resume gives id_pc=6 next cycle; with FETCH_PERF_EN, perf_stall_cnt=4.
- **Redirect with slot full and stalled:** redirect_pc=40 while id_valid=1, id_ready=0.
  - Next cycle id_valid=0.
  - Following cycle id_pc=40, id_instr=0x1028.
- **Fault:** redirect_pc=62, id_ready=1.
  - id_pc=62,63 delivered; fetch_fault=1 when pc reaches 64; no further id_valid.
  - Redirect to 0 clears fetch_fault, and id_pc=0 follows two cycles later.
- **Simultaneous redirect and accept at pc=10:**
  - Instruction 10 is never presented.
  - Next presented id_pc = redirect target.
- **Reset mid-stream:** rst_n=0 for one cycle with id_valid=1.
  - id_valid=0, fetch_fault=0 and imem_addr=RESET_PC in the next cycle.
